multi_cycle_ctrl: RTL and testbench

- Moore-style main control FSM for the multi-cycle CPU datapath.
- Sits directly upstream of the ALU control stage: produces ALUOp_o, which feeds ALU_Ctrl's ALUOp_i, plus every datapath enable and mux select.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and stalls on a memory ready handshake.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_out_decode.sv | 79 +++++++
 rtl/multi_cycle_ctrl.sv | 119 +++++++++++
 tb/tb_multi_cycle_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU main control FSM.
package ctrl_pkg;

    localparam int unsigned OPC_W   = 6;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        EXEC_LUI = 4'd5,
        WB_I     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WB   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12
    } state_t;

    localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPC_W-1:0] OP_LUI  = 6'b001111;
    localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OPC_W-1:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_FU    = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_known_op(input logic [OPC_W-1:0] op);
        return op inside {OP_R, OP_ADDI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state-to-control table for the multi-cycle main FSM.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t           state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             zero,
    input  logic             is_bne,
    output ctrl_t            ctrl
);

    // Per-state control values; anything not set stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // PC+4 and IR commit only on the cycle the fetch completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.illegal   = !is_known_op(opcode);
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            WB_R: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            EXEC_LUI: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FU;
            end
            WB_I: begin
                ctrl.reg_write = 1'b1;
            end
            MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = is_bne ? ~zero : zero;
            end
            JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle CPU: state register, sequencing and
// the opcode flags captured in DECODE.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 6,
    parameter int unsigned ST_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode_i,
    input  logic            mem_ready_i,
    input  logic            zero_i,
    output logic [1:0]      ALUOp_o,
    output logic            ALUSrcA_o,
    output logic [1:0]      ALUSrcB_o,
    output logic            IorD_o,
    output logic            MemRead_o,
    output logic            MemWrite_o,
    output logic            IRWrite_o,
    output logic            RegDst_o,
    output logic            MemtoReg_o,
    output logic            RegWrite_o,
    output logic [1:0]      PCSource_o,
    output logic            PCWrite_o,
    output logic            illegal_o,
    output logic [ST_W-1:0] state_o
);

    state_t           state;
    state_t           state_next;
    logic             run;
    logic             is_bne;
    logic             is_sw;
    logic [OPC_W-1:0] op;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;

    assign op = OPC_W'(opcode_i);

    // Next-state sequencing; unused encodings fall back to FETCH.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = mem_ready_i ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_R:           state_next = EXEC_R;
                    OP_ADDI:        state_next = EXEC_I;
                    OP_LUI:         state_next = EXEC_LUI;
                    OP_LW, OP_SW:   state_next = MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_J:           state_next = JUMP;
                    default:        state_next = FETCH;
                endcase
            end
            EXEC_R:   state_next = WB_R;
            WB_R:     state_next = FETCH;
            EXEC_I:   state_next = WB_I;
            EXEC_LUI: state_next = WB_I;
            WB_I:     state_next = FETCH;
            MEM_ADDR: state_next = is_sw ? MEM_WR : MEM_RD;
            MEM_RD:   state_next = mem_ready_i ? MEM_WB : MEM_RD;
            MEM_WB:   state_next = FETCH;
            MEM_WR:   state_next = mem_ready_i ? FETCH : MEM_WR;
            BRANCH:   state_next = FETCH;
            JUMP:     state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // State register; the first edge after reset only arms the outputs in FETCH.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            run    <= 1'b0;
            is_bne <= 1'b0;
            is_sw  <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                is_bne <= (op == OP_BNE);
                is_sw  <= (op == OP_SW);
            end
        end
    end

    ctrl_out_decode u_decode (
        .state     (state),
        .opcode    (op),
        .mem_ready (mem_ready_i),
        .zero      (zero_i),
        .is_bne    (is_bne),
        .ctrl      (ctrl)
    );

    // Hold every output low until the FSM has been armed after reset.
    always_comb begin
        ctrl_out = run ? ctrl : '0;
    end

    assign ALUOp_o    = ctrl_out.alu_op;
    assign ALUSrcA_o  = ctrl_out.alu_src_a;
    assign ALUSrcB_o  = ctrl_out.alu_src_b;
    assign IorD_o     = ctrl_out.iord;
    assign MemRead_o  = ctrl_out.mem_read;
    assign MemWrite_o = ctrl_out.mem_write;
    assign IRWrite_o  = ctrl_out.ir_write;
    assign RegDst_o   = ctrl_out.reg_dst;
    assign MemtoReg_o = ctrl_out.mem_to_reg;
    assign RegWrite_o = ctrl_out.reg_write;
    assign PCSource_o = ctrl_out.pc_source;
    assign PCWrite_o  = ctrl_out.pc_write;
    assign illegal_o  = ctrl_out.illegal;
    assign state_o    = ST_W'(state);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl.
module tb_multi_cycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       illegal;
    logic [3:0] state_o;
    logic [15:0] obs;

    int checks   = 0;
    int failures = 0;

    // Field groups: {ALUOp, SrcA, SrcB, {IorD MemRd MemWr IRWr RegDst MemtoReg RegWr},
    //                PCSource, {PCWrite illegal}}
    localparam logic [15:0] E_IDLE       = 16'h0000;
    localparam logic [15:0] E_FETCH_RDY  = {2'b00, 1'b0, 2'b01, 7'b0101000, 2'b00, 2'b10};
    localparam logic [15:0] E_FETCH_WAIT = {2'b00, 1'b0, 2'b01, 7'b0100000, 2'b00, 2'b00};
    localparam logic [15:0] E_DECODE     = {2'b00, 1'b0, 2'b11, 7'b0000000, 2'b00, 2'b00};
    localparam logic [15:0] E_ILL        = {2'b00, 1'b0, 2'b11, 7'b0000000, 2'b00, 2'b01};
    localparam logic [15:0] E_EXEC_R     = {2'b10, 1'b1, 2'b00, 7'b0000000, 2'b00, 2'b00};
    localparam logic [15:0] E_WB_R       = {2'b00, 1'b0, 2'b00, 7'b0000101, 2'b00, 2'b00};
    localparam logic [15:0] E_EXEC_I     = {2'b00, 1'b1, 2'b10, 7'b0000000, 2'b00, 2'b00};
    localparam logic [15:0] E_EXEC_LUI   = {2'b11, 1'b0, 2'b10, 7'b0000000, 2'b00, 2'b00};
    localparam logic [15:0] E_WB_I       = {2'b00, 1'b0, 2'b00, 7'b0000001, 2'b00, 2'b00};
    localparam logic [15:0] E_MEM_RD     = {2'b00, 1'b0, 2'b00, 7'b1100000, 2'b00, 2'b00};
    localparam logic [15:0] E_MEM_WB     = {2'b00, 1'b0, 2'b00, 7'b0000011, 2'b00, 2'b00};
    localparam logic [15:0] E_MEM_WR     = {2'b00, 1'b0, 2'b00, 7'b1010000, 2'b00, 2'b00};
    localparam logic [15:0] E_BR_T       = {2'b01, 1'b1, 2'b00, 7'b0000000, 2'b01, 2'b10};
    localparam logic [15:0] E_BR_NT      = {2'b01, 1'b1, 2'b00, 7'b0000000, 2'b01, 2'b00};
    localparam logic [15:0] E_JUMP       = {2'b00, 1'b0, 2'b00, 7'b0000000, 2'b10, 2'b10};

    localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, LUI = 6'b001111, LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    assign obs = {alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, pc_source, pc_write, illegal};

    multi_cycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .opcode_i    (opcode),
        .mem_ready_i (mem_ready),
        .zero_i      (zero),
        .ALUOp_o     (alu_op),
        .ALUSrcA_o   (alu_src_a),
        .ALUSrcB_o   (alu_src_b),
        .IorD_o      (iord),
        .MemRead_o   (mem_read),
        .MemWrite_o  (mem_write),
        .IRWrite_o   (ir_write),
        .RegDst_o    (reg_dst),
        .MemtoReg_o  (mem_to_reg),
        .RegWrite_o  (reg_write),
        .PCSource_o  (pc_source),
        .PCWrite_o   (pc_write),
        .illegal_o   (illegal),
        .state_o     (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Leaves the DUT armed in FETCH at a falling edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = R;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d want=0", state_o);
        end
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", obs, E_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL release_before_edge got=%h want=%h", obs, E_IDLE);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0 || obs !== E_FETCH_RDY) begin
            failures++;
            $display("FAIL first_fetch state=%0d out=%h want state=0 out=%h",
                     state_o, obs, E_FETCH_RDY);
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  ops [6];
        logic        rdy [6];
        logic [3:0]  sts [6];
        logic [15:0] exp [6];
        ops = '{R, R, R, BAD, LW, R};
        rdy = '{0, 1, 1, 1, 1, 1};
        sts = '{0, 0, 1, 2, 3, 0};
        exp = '{E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_EXEC_R, E_WB_R, E_FETCH_RDY};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i]; mem_ready = rdy[i]; zero = 1'b0;
            #1;
            checks++;
            if (state_o !== sts[i] || obs !== exp[i]) begin
                failures++;
                $display("FAIL rtype[%0d] state=%0d out=%h want state=%0d out=%h",
                         i, state_o, obs, sts[i], exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_stall();
        logic        rdy [9];
        logic [3:0]  sts [9];
        logic [15:0] exp [9];
        rdy = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        sts = '{0, 1, 7, 8, 8, 8, 8, 9, 0};
        exp = '{E_FETCH_RDY, E_DECODE, E_EXEC_I, E_MEM_RD, E_MEM_RD, E_MEM_RD, E_MEM_RD,
                E_MEM_WB, E_FETCH_RDY};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            opcode = (i == 1) ? LW : BAD; mem_ready = rdy[i]; zero = 1'b1;
            #1;
            checks++;
            if (state_o !== sts[i] || obs !== exp[i]) begin
                failures++;
                $display("FAIL lw[%0d] state=%0d out=%h want state=%0d out=%h",
                         i, state_o, obs, sts[i], exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops [4];
        logic        zs  [4];
        logic [15:0] exp [4];
        ops = '{BEQ, BEQ, BNE, BNE};
        zs  = '{1, 0, 1, 0};
        exp = '{E_BR_T, E_BR_NT, E_BR_NT, E_BR_T};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b1; opcode = ops[k]; zero = ~zs[k];
            @(negedge clk);
            #1;
            checks++;
            if (state_o !== 4'd1 || obs !== E_DECODE) begin
                failures++;
                $display("FAIL br_decode[%0d] state=%0d out=%h want state=1 out=%h",
                         k, state_o, obs, E_DECODE);
            end
            @(negedge clk);
            opcode = R; zero = zs[k];
            #1;
            checks++;
            if (state_o !== 4'd11 || obs !== exp[k]) begin
                failures++;
                $display("FAIL branch[%0d] state=%0d out=%h want state=11 out=%h",
                         k, state_o, obs, exp[k]);
            end
            @(negedge clk);
            #1;
            checks++;
            if (state_o !== 4'd0) begin
                failures++;
                $display("FAIL br_return[%0d] state=%0d want=0", k, state_o);
            end
        end
    endtask

    task automatic test_imm_jump();
        logic [5:0]  ops [11];
        logic [3:0]  sts [11];
        logic [15:0] exp [11];
        ops = '{R, LUI, R, R, R, ADDI, R, R, R, J, R};
        sts = '{0, 1, 5, 6, 0, 1, 4, 6, 0, 1, 12};
        exp = '{E_FETCH_RDY, E_DECODE, E_EXEC_LUI, E_WB_I, E_FETCH_RDY, E_DECODE, E_EXEC_I,
                E_WB_I, E_FETCH_RDY, E_DECODE, E_JUMP};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            opcode = ops[i]; mem_ready = 1'b1; zero = 1'b0;
            #1;
            checks++;
            if (state_o !== sts[i] || obs !== exp[i]) begin
                failures++;
                $display("FAIL imm_jump[%0d] state=%0d out=%h want state=%0d out=%h",
                         i, state_o, obs, sts[i], exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops [4];
        logic [3:0]  sts [4];
        logic [15:0] exp [4];
        ops = '{BAD, BAD, BAD, R};
        sts = '{0, 1, 0, 1};
        exp = '{E_FETCH_RDY, E_ILL, E_FETCH_RDY, E_DECODE};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i]; mem_ready = 1'b1; zero = 1'b1;
            #1;
            checks++;
            if (state_o !== sts[i] || obs !== exp[i]) begin
                failures++;
                $display("FAIL illegal[%0d] state=%0d out=%h want state=%0d out=%h",
                         i, state_o, obs, sts[i], exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_reset();
        logic        rdy [8];
        logic [3:0]  sts [8];
        logic [15:0] exp [8];
        rdy = '{1, 1, 1, 0, 1, 1, 1, 0};
        sts = '{0, 1, 7, 10, 10, 0, 1, 7};
        exp = '{E_FETCH_RDY, E_DECODE, E_EXEC_I, E_MEM_WR, E_MEM_WR, E_FETCH_RDY, E_DECODE,
                E_EXEC_I};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            opcode = (i == 1 || i == 6) ? SW : R; mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== sts[i] || obs !== exp[i]) begin
                failures++;
                $display("FAIL sw[%0d] state=%0d out=%h want state=%0d out=%h",
                         i, state_o, obs, sts[i], exp[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (state_o !== 4'd10 || obs !== E_MEM_WR) begin
            failures++;
            $display("FAIL sw_wait state=%0d out=%h want state=10 out=%h",
                     state_o, obs, E_MEM_WR);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || mem_write !== 1'b0 || obs !== E_IDLE) begin
            failures++;
            $display("FAIL async_reset state=%0d out=%h want state=0 out=%h",
                     state_o, obs, E_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL post_reset_quiet out=%h want=%h", obs, E_IDLE);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0 || obs !== E_FETCH_RDY) begin
            failures++;
            $display("FAIL post_reset_fetch state=%0d out=%h want state=0 out=%h",
                     state_o, obs, E_FETCH_RDY);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd1) begin
            failures++;
            $display("FAIL post_reset_decode state=%0d want=1", state_o);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = R;
        mem_ready = 1'b0;
        zero      = 1'b0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_imm_jump();
        test_illegal();
        test_sw_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
